matrix_mult_engine: RTL and testbench

Matrix multiplication engine sitting directly below the accelerator top-level memory controller. It is enabled by the control unit once the host has written operation code 1 and the go word. It fetches the dimensions and operands from the shared DFFRAM through the single-port request/opdone memory handshake, computes C = A x B and writes C back into DFFRAM after the operands. It then raises done.

---
 rtl/matrix_mult_engine_if.sv | 10 +
 rtl/matrix_mult_engine.sv | 185 ++++++++++++++++++
 tb/tb_matrix_mult_engine.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_engine_if.sv
// matrix_mult_engine_if: single-port DFFRAM request/opdone handshake between engine and memory controller.
interface matrix_mult_engine_if #(parameter int DATA_W = 32);
    logic [31:0]       addr_o;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        mem_operation;
    logic              mem_opdone;
    modport master (output addr_o, data_o, mem_operation, input data_i, mem_opdone);
    modport slave  (input addr_o, data_o, mem_operation, output data_i, mem_opdone);
endinterface

// File: rtl/matrix_mult_engine.sv
// matrix_mult_engine: reads dims and A/B from DFFRAM, computes C = A x B and writes C after the operands.
// Define MMUL_SAT_EN for a saturating, per-element sticky accumulator; default wraps modulo 2^DATA_W.
module matrix_mult_engine #(
    parameter int DATA_W   = 32,
    parameter int MEM_SIZE = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 enable,
    output logic                 done,
    output logic                 error,
    matrix_mult_engine_if.master mem
);
    typedef enum logic [2:0] {IDLE, RD_DIM, CHECK, RD_A, RD_B, MAC, WR_C, DONE} state_t;
    localparam logic [1:0]  OP_NONE = 2'b00, OP_RD = 2'b01, OP_WR = 2'b11;
    localparam logic [31:0] MSZ = 32'(MEM_SIZE);

    state_t                   state_q, state_d;
    logic [1:0]               op_q, op_d, cnt_q, cnt_d;
    logic [31:0]              addr_q, addr_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic [31:0]              dims_q [4];
    logic [31:0]              dims_d [4];
    logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, data_q, data_d, acc_mac;
    logic                     error_q, error_d;
    logic [31:0]              base_b, base_c;
    logic                     bad, busy, fire;

    // dims are [0]=K, [1]=M, [2]=N, [3]=KB
    assign base_b = 32'd6 + dims_q[1] * dims_q[0];
    assign base_c = base_b + dims_q[0] * dims_q[2];
    // any single dimension above MEM_SIZE already overflows memory, and rejecting it first keeps the products from wrapping
    assign bad = dims_q[0] != dims_q[3] || dims_q[0] == '0 || dims_q[1] == '0 || dims_q[2] == '0 ||
                 dims_q[0] > MSZ || dims_q[1] > MSZ || dims_q[2] > MSZ ||
                 base_c + dims_q[1] * dims_q[2] > MSZ;
    assign busy = op_q != OP_NONE;
    assign fire = busy && mem.mem_opdone;

`ifdef MMUL_SAT_EN
    logic                       sat_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W:0]   sum;
    logic                       fits;
    assign prod = a_q * b_q;
    assign sum  = acc_q + prod;
    assign fits = &sum[2*DATA_W:DATA_W-1] | ~|sum[2*DATA_W:DATA_W-1];
    assign acc_mac = sat_q ? acc_q : fits ? sum[DATA_W-1:0] : {sum[2*DATA_W], {(DATA_W-1){~sum[2*DATA_W]}}};
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) sat_q <= 1'b0;
        else if (state_q == MAC) sat_q <= sat_q | ~fits;
        else if (state_q == CHECK || (state_q == WR_C && fire)) sat_q <= 1'b0;
    end
`else
    assign acc_mac = acc_q + a_q * b_q;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            dims_q  <= '{default: '0};
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dims_q  <= dims_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dims_d  = dims_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = RD_DIM;
            end
            RD_DIM: begin
                if (!busy) begin
                    op_d   = OP_RD;
                    addr_d = 32'(cnt_q) + 32'd1;
                end else if (fire) begin
                    op_d          = OP_NONE;
                    dims_d[cnt_q] = 32'(mem.data_i);
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = CHECK;
                end
            end
            CHECK: begin
                error_d = bad;
                state_d = bad ? DONE : RD_A;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                acc_d   = '0;
            end
            RD_A: begin
                if (!busy) begin
                    op_d   = OP_RD;
                    addr_d = 32'd6 + i_q * dims_q[0] + k_q;
                end else if (fire) begin
                    op_d    = OP_NONE;
                    a_d     = mem.data_i;
                    state_d = RD_B;
                end
            end
            RD_B: begin
                if (!busy) begin
                    op_d   = OP_RD;
                    addr_d = base_b + k_q * dims_q[2] + j_q;
                end else if (fire) begin
                    op_d    = OP_NONE;
                    b_d     = mem.data_i;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d   = acc_mac;
                k_d     = k_q + 32'd1;
                state_d = k_q + 32'd1 == dims_q[0] ? WR_C : RD_A;
            end
            WR_C: begin
                if (!busy) begin
                    op_d   = OP_WR;
                    addr_d = base_c + i_q * dims_q[2] + j_q;
                    data_d = acc_q;
                end else if (fire) begin
                    op_d    = OP_NONE;
                    acc_d   = '0;
                    k_d     = '0;
                    j_d     = j_q + 32'd1 == dims_q[2] ? '0 : j_q + 32'd1;
                    i_d     = j_q + 32'd1 == dims_q[2] ? i_q + 32'd1 : i_q;
                    state_d = (j_q + 32'd1 == dims_q[2] && i_q + 32'd1 == dims_q[1]) ? DONE : RD_A;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                    error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort: drop any pending request; a late opdone is ignored because op is then idle
        if (!enable && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            op_d    = OP_NONE;
        end
    end

    assign mem.addr_o        = addr_q;
    assign mem.data_o        = data_q;
    assign mem.mem_operation = op_q;
    assign done              = state_q == DONE;
    assign error             = error_q;
endmodule

// File: tb/tb_matrix_mult_engine.sv
// tb_matrix_mult_engine: random-latency DFFRAM responder plus a plain-arithmetic matrix product reference.
module tb_matrix_mult_engine;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic done, error;
    matrix_mult_engine_if #(.DATA_W(32)) mif();
    matrix_mult_engine #(.DATA_W(32), .MEM_SIZE(256)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .done(done), .error(error), .mem(mif.master));
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          checks = 0, errors = 0;
    int          max_dly = 0, rd_cnt = 0, exp_rd = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    bit          stall_wr = 1'b0, exp_err = 1'b0;
    logic [31:0] wr_a [$], wr_d [$], exp_a [$], exp_d [$];
    int          a_v [128], b_v [128];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory responder: random latency, checks request stability and the idle gap after opdone
    initial begin
        logic [1:0]  op;
        logic [31:0] a, d;
        int          dly;
        mif.mem_opdone = 1'b0;
        mif.data_i     = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && mif.mem_operation != 2'b00) begin
                op = mif.mem_operation;
                a  = mif.addr_o;
                d  = mif.data_o;
                if ((op == 2'b01 && a >= stall_addr) || (op == 2'b11 && stall_wr)) begin
                    for (int t = 0; t < 1000 && mif.mem_operation != 2'b00; t++) begin
                        @(posedge clk); #1;
                    end
                    mif.mem_opdone = 1'b1;
                    @(posedge clk); #1;
                    mif.mem_opdone = 1'b0;
                end else begin
                    dly = $urandom_range(max_dly, 0);
                    repeat (dly) begin
                        @(posedge clk); #1;
                        check("hold_op", mif.mem_operation, op);
                        check("hold_addr", mif.addr_o, a);
                        if (op == 2'b11) check("hold_data", mif.data_o, d);
                    end
                    if (op == 2'b01) begin
                        mif.data_i = a < 256 ? mem[a[7:0]] : 32'hDEAD_BEEF;
                        rd_cnt++;
                    end else begin
                        if (a < 256) mem[a[7:0]] = d;
                        wr_a.push_back(a);
                        wr_d.push_back(d);
                    end
                    mif.mem_opdone = 1'b1;
                    @(posedge clk); #1;
                    mif.mem_opdone = 1'b0;
                    check("gap", mif.mem_operation, 2'b00);
                end
            end
        end
    end

    // mode: 0 = use a_v/b_v as preset, 1 = small random, 2 = full-range random
    task automatic setup_case(input int K, input int M, input int N, input int KB, input int mode);
        int bb, bc;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = 32'(K);
        mem[2] = 32'(M);
        mem[3] = 32'(N);
        mem[4] = 32'(KB);
        exp_a.delete();
        exp_d.delete();
        exp_err = K != KB || K == 0 || M == 0 || N == 0 || (6 + M*K + K*N + M*N > 256);
        exp_rd  = exp_err ? 4 : 4 + 2*M*N*K;
        if (!exp_err) begin
            bb = 6 + M*K;
            bc = bb + K*N;
            for (int i = 0; i < M*K; i++) begin
                if (mode != 0) a_v[i] = mode == 2 ? int'($urandom) : int'($urandom_range(200)) - 100;
                mem[6 + i] = 32'(a_v[i]);
            end
            for (int i = 0; i < K*N; i++) begin
                if (mode != 0) b_v[i] = mode == 2 ? int'($urandom) : int'($urandom_range(200)) - 100;
                mem[bb + i] = 32'(b_v[i]);
            end
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
`ifdef MMUL_SAT_EN
                    longint acc;
                    bit     sat;
                    acc = 0;
                    sat = 1'b0;
                    for (int k = 0; k < K; k++)
                        if (!sat) begin
                            acc += longint'(a_v[i*K + k]) * longint'(b_v[k*N + j]);
                            if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; sat = 1'b1; end
                            else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1'b1; end
                        end
`else
                    int acc;
                    acc = 0;
                    for (int k = 0; k < K; k++) acc += a_v[i*K + k] * b_v[k*N + j];
`endif
                    exp_a.push_back(32'(bc + i*N + j));
                    exp_d.push_back(32'(acc));
                end
        end
    endtask

    task automatic run_check(input string tag);
        bit ok;
        ok = 1'b0;
        wr_a.delete();
        wr_d.delete();
        rd_cnt = 0;
        enable = 1'b1;
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
        check({tag, "_done"}, ok, 1);
        check({tag, "_err"}, error, exp_err);
        check({tag, "_nrd"}, rd_cnt, exp_rd);
        check({tag, "_nwr"}, wr_a.size(), exp_a.size());
        for (int n = 0; n < exp_a.size() && n < wr_a.size(); n++) begin
            check({tag, "_addr"}, wr_a[n], exp_a[n]);
            check({tag, "_data"}, wr_d[n], exp_d[n]);
        end
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_hold_done"}, done, 1);
        check({tag, "_hold_op"}, mif.mem_operation, 2'b00);
        enable = 1'b0;
        @(posedge clk); #1;
        check({tag, "_clr_done"}, done, 0);
        check({tag, "_clr_err"}, error, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, error, 0);
        check({tag, "_addr"}, mif.addr_o, 0);
        check({tag, "_data"}, mif.data_o, 0);
        check({tag, "_op"}, mif.mem_operation, 2'b00);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        a_v[0] = 1; a_v[1] = 0; a_v[2] = 0; a_v[3] = 1;
        b_v[0] = 5; b_v[1] = 6; b_v[2] = 7; b_v[3] = 8;
        setup_case(2, 2, 2, 2, 0);
        run_check("ident");
        for (int n = 0; n < wr_d.size() && n < 4; n++) begin
            check("ident_c_addr", wr_a[n], 14 + n);
            check("ident_c_data", wr_d[n], 5 + n);
        end

        a_v[0] = 1; a_v[1] = 2; a_v[2] = 3;
        b_v[0] = 4; b_v[1] = 5; b_v[2] = 6;
        setup_case(3, 1, 1, 3, 0);
        run_check("dot");
        if (wr_d.size() > 0) begin
            check("dot_addr", wr_a[0], 12);
            check("dot_data", wr_d[0], 32'h20);
        end

        setup_case(3, 2, 2, 2, 0);
        run_check("mismatch");
        setup_case(2, 0, 2, 2, 0);
        run_check("m_zero");
        setup_case(10, 10, 10, 10, 0);
        run_check("oob");
        setup_case(4, 10, 16, 4, 1);
        run_check("oob_edge");
        setup_case(4, 10, 15, 4, 1);
        run_check("fit_edge");

        a_v[0] = 32'h7FFF_FFFF;
        b_v[0] = 2;
        setup_case(1, 1, 1, 1, 0);
        run_check("ovf");
        if (wr_d.size() > 0) begin
            check("ovf_addr", wr_a[0], 8);
`ifdef MMUL_SAT_EN
            check("ovf_data", wr_d[0], 32'h7FFF_FFFF);
`else
            check("ovf_data", wr_d[0], 32'hFFFF_FFFE);
`endif
        end

        max_dly = 7;
        a_v[0] = 1; a_v[1] = 0; a_v[2] = 0; a_v[3] = 1;
        b_v[0] = 5; b_v[1] = 6; b_v[2] = 7; b_v[3] = 8;
        setup_case(2, 2, 2, 2, 0);
        run_check("slow_ident");

        for (int r = 0; r < 10; r++) begin
            int K, M, N;
            max_dly = $urandom_range(7);
            K = $urandom_range(4, 1);
            M = $urandom_range(4, 1);
            N = $urandom_range(4, 1);
            setup_case(K, M, N, $urandom_range(7) == 0 ? K + 1 : K, $urandom_range(2, 1));
            run_check("rand");
        end

        max_dly = 2;
        setup_case(2, 2, 2, 2, 1);
        stall_addr = 32'd10;
        enable = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk); #1;
            if (mif.mem_operation == 2'b01 && mif.addr_o >= 32'd10) begin found = 1'b1; break; end
        end
        check("abort_reach_rdb", found, 1);
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_op", mif.mem_operation, 2'b00);
        check("abort_done", done, 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("abort_idle_op", mif.mem_operation, 2'b00);
            check("abort_idle_done", done, 0);
        end
        stall_addr = 32'hFFFF_FFFF;
        run_check("rerun");

        setup_case(2, 2, 2, 2, 1);
        stall_wr = 1'b1;
        enable = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk); #1;
            if (mif.mem_operation == 2'b11) begin found = 1'b1; break; end
        end
        check("rst_reach_wrc", found, 1);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        stall_wr = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        run_check("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
